// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- run-time configurable UART transmitter with a local TX FIFO.
//
// A bus-side writer pushes words into a FIFO. A frame FSM pops them and
// serialises each one as start, DATA_W data bits (LSB first), an optional
// parity bit and one or two stop bits. The bit period is baud_div_i+1 clocks.
//
// Ports
//   clock_i / reset_i     rising-edge clock, synchronous active-high reset
//   data_i, data_write_i  enqueue one word per cycle
//   full_tresh_i          almost-full threshold (0 selects FIFO_DEPTH)
//   baud_div_i            bit period minus one, in clocks
//   parity_mode_i         00/11 none, 01 even, 10 odd
//   stop2_i               two stop bits when set
//   tx_enable_i           allow new frames to start
//   data_buffer_full_o    fill >= effective threshold (registered)
//   data_buffer_empty_o   fill == 0 (registered)
//   fill_level_o          FIFO occupancy 0..FIFO_DEPTH
//   overflow_o            one-cycle pulse when a write is dropped
//   busy_o                FSM not idle
//   uart_tx_o             registered serial line, idle high
module uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_write_i,
  input  logic [AW:0]       full_tresh_i,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic [1:0]        parity_mode_i,
  input  logic              stop2_i,
  input  logic              tx_enable_i,
  output logic              data_buffer_full_o,
  output logic              data_buffer_empty_o,
  output logic [AW:0]       fill_level_o,
  output logic              overflow_o,
  output logic              busy_o,
  output logic              uart_tx_o
);

  localparam int          BIT_W = $clog2(DATA_W);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Per-frame configuration, captured when the word is popped so that
  // input changes mid-frame only affect the next frame.
  typedef struct packed {
    logic             par_en;
    logic             par_bit;
    logic             stop2;
    logic [DIV_W-1:0] div;
  } frame_cfg_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fill, fill_n, thr_eff;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  assign head    = mem[rd_ptr];
  // A full FIFO still takes a write when the FSM pops in the same cycle.
  assign push    = data_write_i && ((fill != DEPTH) || pop);
  assign thr_eff = (full_tresh_i == '0) ? DEPTH : full_tresh_i;

  always_comb begin
    fill_n = fill;
    case ({push, pop})
      2'b10:   fill_n = fill + (AW+1)'(1);
      2'b01:   fill_n = fill - (AW+1)'(1);
      default: fill_n = fill;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fill                <= '0;
      data_buffer_full_o  <= 1'b0;
      data_buffer_empty_o <= 1'b1;
      overflow_o          <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fill                <= fill_n;
      data_buffer_full_o  <= (fill_n >= thr_eff);
      data_buffer_empty_o <= (fill_n == '0);
      overflow_o          <= data_write_i && !push;
    end
  end

  assign fill_level_o = fill;

  // ---------------------------------------------------------------- frame FSM
  state_t            state, state_n;
  logic [DIV_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bit_idx, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  frame_cfg_t        cfg, cfg_n, cfg_load;
  logic              start_ok, bit_end, tx_n;

  assign start_ok = tx_enable_i && (fill != '0);
  assign bit_end  = (cnt == cfg.div);

  // Odd parity is the inverse of even; parity_mode_i[1] selects odd.
  assign cfg_load = '{par_en:  (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10),
                      par_bit: (^head) ^ parity_mode_i[1],
                      stop2:   stop2_i,
                      div:     baud_div_i};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    cfg_n   = cfg;
    pop     = 1'b0;
    tx_n    = 1'b1;

    case (state)
      S_IDLE: begin
        if (start_ok) begin
          pop     = 1'b1;
          state_n = S_START;
          cnt_n   = '0;
          bit_n   = '0;
          shreg_n = head;
          cfg_n   = cfg_load;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          cnt_n   = '0;
          bit_n   = '0;
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shreg_n = shreg >> 1;
          if (bit_idx == BIT_W'(DATA_W-1)) begin
            state_n = cfg.par_en ? S_PARITY : S_STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          cnt_n   = '0;
          bit_n   = '0;
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (cfg.stop2 && (bit_idx == '0)) begin
            bit_n = BIT_W'(1);
          end else if (start_ok) begin
            // Back-to-back frame: no idle gap after the last stop bit.
            pop     = 1'b1;
            state_n = S_START;
            bit_n   = '0;
            shreg_n = head;
            cfg_n   = cfg_load;
          end else begin
            state_n = S_IDLE;
            bit_n   = '0;
          end
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        bit_n   = '0;
      end
    endcase

    // The line is registered from the next-state view so it changes on
    // the same edge the FSM enters a bit.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = cfg_n.par_bit;
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      cfg       <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shreg     <= shreg_n;
      cfg       <= cfg_n;
      uart_tx_o <= tx_n;
    end
  end

  assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV_W      = 16;
  localparam int AW         = 4;

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic [DATA_W-1:0] data_i;
  logic              data_write_i;
  logic [AW:0]       full_tresh_i;
  logic [DIV_W-1:0]  baud_div_i;
  logic [1:0]        parity_mode_i;
  logic              stop2_i;
  logic              tx_enable_i;
  logic              data_buffer_full_o;
  logic              data_buffer_empty_o;
  logic [AW:0]       fill_level_o;
  logic              overflow_o;
  logic              busy_o;
  logic              uart_tx_o;

  uart_tx_cfg #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .data_i              (data_i),
    .data_write_i        (data_write_i),
    .full_tresh_i        (full_tresh_i),
    .baud_div_i          (baud_div_i),
    .parity_mode_i       (parity_mode_i),
    .stop2_i             (stop2_i),
    .tx_enable_i         (tx_enable_i),
    .data_buffer_full_o  (data_buffer_full_o),
    .data_buffer_empty_o (data_buffer_empty_o),
    .fill_level_o        (fill_level_o),
    .overflow_o          (overflow_o),
    .busy_o              (busy_o),
    .uart_tx_o           (uart_tx_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock_i);
    reset_i      = 1'b1;
    data_write_i = 1'b0;
    tx_enable_i  = 1'b0;
    @(negedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clock_i);
    data_i       = d;
    data_write_i = 1'b1;
    @(negedge clock_i);
    data_write_i = 1'b0;
  endtask

  // Scan for a start bit, one cycle at a time, for at most budget cycles.
  task automatic wait_start(input int budget, output bit found, output int t);
    found = 1'b0;
    t     = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clock_i);
      if (uart_tx_o === 1'b0) begin
        found = 1'b1;
        t     = cyc;
      end
    end
  endtask

  // Called on the first cycle of a start bit; samples the first cycle of each
  // following bit and returns on the last cycle of the final bit.
  task automatic get_bits(input int div, input int n, output logic [11:0] line);
    line    = '1;
    line[0] = 1'b0;
    for (int k = 1; k < n; k++) begin
      repeat (div + 1) @(negedge clock_i);
      line[k] = uart_tx_o;
    end
    repeat (div) @(negedge clock_i);
  endtask

  // Line patterns: bit k is the k-th bit on the wire (start first).
  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  pmode;
    logic        stop2;
    logic [11:0] line;
    int          nbits;
  } vec_t;

  vec_t        vecs[6];
  int          nbad, nlo, per;
  logic        expb;
  bit          f1, f2, f3, f4;
  int          t1, t2, t3, t4, nov, ov_at;
  logic [11:0] l1, l2, l3;

  initial begin
    #500_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hA5, 16'd3, 2'b00, 1'b0, 12'h34A, 10}; // 40 clocks
    vecs[1] = '{8'h07, 16'd0, 2'b10, 1'b1, 12'hC0E, 12}; // odd: parity 0
    vecs[2] = '{8'h07, 16'd0, 2'b01, 1'b1, 12'hE0E, 12}; // even: parity 1
    vecs[3] = '{8'h3C, 16'd1, 2'b01, 1'b0, 12'h478, 11}; // even, 4 ones: 0
    vecs[4] = '{8'h80, 16'd2, 2'b10, 1'b0, 12'h500, 11}; // odd, 1 one: 0
    vecs[5] = '{8'hFF, 16'd0, 2'b11, 1'b1, 12'h7FE, 11}; // mode 11 = none

    reset_i       = 1'b1;
    data_i        = '0;
    data_write_i  = 1'b0;
    full_tresh_i  = '0;
    baud_div_i    = '0;
    parity_mode_i = 2'b00;
    stop2_i       = 1'b0;
    tx_enable_i   = 1'b0;
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    check("reset_state",
          {data_buffer_full_o, data_buffer_empty_o, fill_level_o, overflow_o, busy_o, uart_tx_o},
          {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1});

    // ---- single frames from the table
    tx_enable_i = 1'b1;
    for (int v = 0; v < 6; v++) begin
      per = int'(vecs[v].div) + 1;
      @(negedge clock_i);
      data_i        = vecs[v].data;
      baud_div_i    = vecs[v].div;
      parity_mode_i = vecs[v].pmode;
      stop2_i       = vecs[v].stop2;
      data_write_i  = 1'b1;
      @(negedge clock_i);
      data_write_i = 1'b0;
      check($sformatf("v%0d_latency_fill", v), {fill_level_o, uart_tx_o}, {5'd1, 1'b1});
      nbad = 0;
      nlo  = 0;
      for (int k = 0; k < vecs[v].nbits * per; k++) begin
        @(negedge clock_i);
        expb = vecs[v].line[k / per];
        if (uart_tx_o !== expb) nbad++;
        if (busy_o !== 1'b1) nlo++;
      end
      check($sformatf("v%0d_frame_bits", v), nbad, 0);
      check($sformatf("v%0d_busy_in_frame", v), nlo, 0);
      @(negedge clock_i);
      check($sformatf("v%0d_post_idle", v), {busy_o, uart_tx_o, data_buffer_empty_o}, 3'b011);
    end

    // ---- almost-full threshold
    do_reset();
    full_tresh_i = 5'd4;
    for (int i = 0; i < 3; i++) push(8'(i));
    check("thr4_fill3", {fill_level_o, data_buffer_full_o, data_buffer_empty_o}, {5'd3, 1'b0, 1'b0});
    push(8'h03);
    check("thr4_fill4", {fill_level_o, data_buffer_full_o}, {5'd4, 1'b1});
    @(negedge clock_i);
    full_tresh_i = 5'd0;
    @(negedge clock_i);
    check("thr0_fill4", {fill_level_o, data_buffer_full_o}, {5'd4, 1'b0});
    for (int i = 4; i < 15; i++) push(8'(i));
    check("thr0_fill15", {fill_level_o, data_buffer_full_o}, {5'd15, 1'b0});
    push(8'h0F);
    check("thr0_fill16", {fill_level_o, data_buffer_full_o}, {5'd16, 1'b1});

    // ---- overflow: 17 back-to-back writes, transmitter disabled
    do_reset();
    full_tresh_i = 5'd0;
    nov   = 0;
    ov_at = -1;
    @(negedge clock_i);
    data_i       = 8'h10;
    data_write_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clock_i);
      if (overflow_o === 1'b1) begin
        nov++;
        ov_at = i;
      end
      if (i < 16) data_i = 8'(8'h10 + i + 1);
      else        data_write_i = 1'b0;
    end
    @(negedge clock_i);
    if (overflow_o === 1'b1) nov++;
    check("ovf_pulse_count", nov, 1);
    check("ovf_pulse_cycle", ov_at, 16);
    check("ovf_fill_full", {fill_level_o, data_buffer_full_o}, {5'd16, 1'b1});

    baud_div_i    = '0;
    parity_mode_i = 2'b00;
    stop2_i       = 1'b0;
    tx_enable_i   = 1'b1;
    nbad = 0;
    for (int i = 0; i < 16; i++) begin
      wait_start(40, f1, t1);
      if (!f1) nbad++;
      else begin
        get_bits(0, 10, l1);
        if (l1[9:0] !== {1'b1, 8'(8'h10 + i), 1'b0}) nbad++;
      end
    end
    check("ovf_drain_data", nbad, 0);
    wait_start(40, f1, t1);
    check("ovf_no_17th", f1, 0);
    check("ovf_drained", {fill_level_o, data_buffer_empty_o, busy_o}, {5'd0, 1'b1, 1'b0});

    // ---- contiguous frames, mid-frame divisor change, enable drop
    do_reset();
    baud_div_i = 16'd1;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    push(8'h34);
    tx_enable_i = 1'b1;
    wait_start(20, f1, t1);
    get_bits(1, 10, l1);
    wait_start(20, f2, t2);
    baud_div_i = 16'd3;
    get_bits(1, 10, l2);
    wait_start(20, f3, t3);
    tx_enable_i = 1'b0;
    get_bits(3, 10, l3);
    check("b2b_found", {f1, f2, f3}, 3'b111);
    check("b2b_gap12", t2 - t1, 20);
    check("b2b_gap23", t3 - t2, 20);
    check("b2b_data1", l1[9:0], {1'b1, 8'h31, 1'b0});
    check("b2b_data2", l2[9:0], {1'b1, 8'h32, 1'b0});
    check("b2b_data3_div3", l3[9:0], {1'b1, 8'h33, 1'b0});
    check("b2b_f3_last_cycle", {cyc - t3, busy_o}, {32'd39, 1'b1});
    @(negedge clock_i);
    check("b2b_f3_done", busy_o, 1'b0);
    wait_start(60, f4, t4);
    check("en_low_no_start", f4, 0);
    check("en_low_fill", {fill_level_o, busy_o}, {5'd1, 1'b0});

    // ---- reset mid-DATA with five words queued
    do_reset();
    baud_div_i = 16'd3;
    for (int i = 0; i < 5; i++) push(8'(8'h41 + i));
    tx_enable_i = 1'b1;
    wait_start(20, f1, t1);
    repeat (14) @(negedge clock_i);
    check("rst_mid_busy", {f1, busy_o}, 2'b11);
    reset_i = 1'b1;
    @(negedge clock_i);
    check("rst_mid_state",
          {uart_tx_o, fill_level_o, busy_o, data_buffer_empty_o},
          {1'b1, 5'd0, 1'b0, 1'b1});
    reset_i = 1'b0;
    wait_start(100, f2, t2);
    check("rst_no_residual", f2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
